fsqrt_sched: RTL and testbench
==============================

FSQRT_SCHED -- requirements
Module: fsqrt_sched

Interface
REQ-001 SHALL have parameter LATENCY, default 2: fsqrt pipeline depth in cycles, from input sample edge to result cycle.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries, power of two, at least LATENCY.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  in  1  synchronous active-low reset.
REQ-006 reqN_valid  in  1  (N=0,1) requester N presents an operand.
REQ-007 reqN_ready  out  1  operand accepted this cycle when valid&ready.
REQ-008 reqN_x  in  32  IEEE-754 single operand.
REQ-009 reqN_rd  in  5  destination register tag.
REQ-010 sq_x  out  32  operand to fsqrt.
REQ-011 sq_flagin / sq_addin  out  1/5  issue-valid / tag to fsqrt passthrough.
REQ-012 sq_y  in  32  fsqrt result.
REQ-013 sq_flagout / sq_addout  in  1/5  passthrough returned by fsqrt.
REQ-014 wb_valid / wb_ready  out/in  1/1  writeback handshake.
REQ-015 wb_data / wb_rd / wb_src  out  32/5/1  result, tag, originating requester.

Function
REQ-016 Issue SHALL be combinational: on accept in cycle t, sq_x=reqN_x, sq_addin=reqN_rd, sq_flagin=1; with no accept, sq_flagin=0 and sq_x=0.
REQ-017 At most one accept per cycle; reqN_ready SHALL NOT depend on wb_ready in the same cycle.
REQ-018 Credit: accept allowed only if inflight+fifo_count < DEPTH, both sampled at cycle start; a same-cycle FIFO pop SHALL NOT free credit.
REQ-019 Round-robin: with both valid, grant the requester not granted last; a lone valid requester wins whenever credit allows; the pointer updates only on accept.
REQ-020 An internal LATENCY-deep shift register SHALL carry {valid, src, rd} per issue; the result is captured from sq_y at cycle t+LATENCY when its valid bit emerges.
REQ-021 sq_flagout and sq_addout SHALL NOT be used for control; a mismatch with the internal shift register is an assertion failure.
REQ-022 Captured results SHALL always be pushed into the FIFO; with FIFO empty, wb_valid rises at t+LATENCY+1.
REQ-023 The FIFO head drives wb_*; a pop occurs on wb_valid&wb_ready; simultaneous push and pop keep the count unchanged.
REQ-024 Results SHALL emerge in issue order; FIFO overflow is unreachable by REQ-018, and an assertion checks it.
REQ-025 Read/write pointers SHALL be log2(DEPTH) bits and wrap naturally; count SHALL be log2(DEPTH)+1 bits.
REQ-026 wb_data/wb_rd/wb_src SHALL stay stable while wb_valid=1 and wb_ready=0.

Reset
REQ-027 While rstn=0: reqN_ready=0, sq_flagin=0, sq_x=0, sq_addin=0, wb_valid=0, wb_data/wb_rd/wb_src=0, inflight valids cleared, FIFO empty, RR pointer=1 (req0 wins first).
REQ-028 Reset mid-operation SHALL discard in-flight and buffered results; stale fsqrt outputs after reset SHALL be ignored (follows from REQ-021).
REQ-029 First accept is possible in the first cycle with rstn=1.

Structure
REQ-030 Package fpu_sched_pkg SHALL hold the typedef of the {valid, src, rd} tag struct and default constants LATENCY=2 and DEPTH=4.
REQ-031 The FIFO SHALL be one sub-module, fsqrt_res_fifo (DEPTH x 38 bits: data, rd, src); arbiter and tag shift register stay in fsqrt_sched.
REQ-032 The fsqrt unit SHALL be instantiated outside and connected by the bench or core.

Verification
REQ-033 req0 x=0x40800000 rd=3 alone, wb_ready=1 -> wb_valid at t+3 with data 0x40000000, rd=3, src=0.
REQ-034 Both valid every cycle (req0 0x3F800000 rd=1, req1 0x41100000 rd=2), wb_ready=1 -> grants alternate 0,1,0,...; results 0x3F800000/0x40400000 alternate in order.
REQ-035 wb_ready=0, req0 valid continuously -> exactly 4 accepts, then ready=0; one wb_ready pulse -> one pop, one more accept next cycle.
REQ-036 Burst of 4 results with wb_ready toggling 1/0 -> no loss or duplication, in-order tags, stable wb_* during stall.
REQ-037 rstn=0 for 1 cycle with 2 in flight and 2 buffered -> wb_valid=0 next cycle; no stale result appears later; next accept of 0x41800000 -> 0x40800000.
REQ-038 Reset with both valid -> req0 granted first.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_sched_pkg : shared types/defaults for the fsqrt issue scheduler  (rev 1.0)
// ---------------------------------------------------------------------------
package fpu_sched_pkg;

   localparam int DEF_LATENCY = 2;
   localparam int DEF_DEPTH   = 4;

   typedef struct packed {
      logic       valid;
      logic       src;
      logic [4:0] rd;
   } tag_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        src;
   } res_t;

endpackage
`default_nettype wire

// File: rtl/fsqrt_res_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fsqrt_res_fifo : in-order result buffer feeding writeback          (rev 1.0)
// ---------------------------------------------------------------------------
module fsqrt_res_fifo
   import fpu_sched_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  res_t                     push_data,
   input  logic                     pop,
   output logic                     valid,
   output res_t                     head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   res_t          mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign valid = (count != '0);
   assign head  = mem[rptr];

   // Credit accounting upstream must make a full-FIFO push impossible.
   assert property (@(posedge clk) disable iff (!rstn)
      (push && !pop) |-> (count < (AW + 1)'(DEPTH)));

endmodule
`default_nettype wire

// File: rtl/fsqrt_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fsqrt_sched : 2-way round-robin issue to an external fixed-latency fsqrt,
//               credit-limited in-order writeback                    (rev 1.0)
// ---------------------------------------------------------------------------
module fsqrt_sched
   import fpu_sched_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int DEPTH   = DEF_DEPTH
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_x,
   input  logic [4:0]  req0_rd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_x,
   input  logic [4:0]  req1_rd,
   output logic [31:0] sq_x,
   output logic        sq_flagin,
   output logic [4:0]  sq_addin,
   input  logic [31:0] sq_y,
   input  logic        sq_flagout,
   input  logic [4:0]  sq_addout,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_src
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;

   tag_t          tags [LATENCY];
   logic          last_src;
   logic [CW-1:0] fifo_count;
   logic          fifo_valid;
   res_t          fifo_head;
   res_t          captured;
   logic [OW-1:0] occupancy;
   logic          credit;
   logic          acc0;
   logic          acc1;
   logic          accept;
   logic          pop;

   // Occupancy uses registered state only, so a pop this cycle frees nothing yet.
   always_comb begin
      occupancy = OW'(fifo_count);
      for (int i = 0; i < LATENCY; i++)
         occupancy = occupancy + OW'(tags[i].valid);
   end

   assign credit     = rstn && (occupancy < OW'(DEPTH));
   assign req0_ready = credit && (!req1_valid || last_src);
   assign req1_ready = credit && (!req0_valid || !last_src);
   assign acc0       = req0_valid && req0_ready;
   assign acc1       = req1_valid && req1_ready;
   assign accept     = acc0 || acc1;

   assign sq_flagin = accept;
   assign sq_x      = acc0 ? req0_x  : (acc1 ? req1_x  : '0);
   assign sq_addin  = acc0 ? req0_rd : (acc1 ? req1_rd : '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_src <= 1'b1;
         for (int i = 0; i < LATENCY; i++)
            tags[i] <= '0;
      end else begin
         if (accept)
            last_src <= acc1;
         tags[0] <= tag_t'{valid: accept, src: acc1, rd: sq_addin};
         for (int i = 1; i < LATENCY; i++)
            tags[i] <= tags[i-1];
      end
   end

   assign captured = res_t'{data: sq_y, rd: tags[LATENCY-1].rd, src: tags[LATENCY-1].src};

   fsqrt_res_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (tags[LATENCY-1].valid),
      .push_data (captured),
      .pop       (pop),
      .valid     (fifo_valid),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign wb_valid = rstn && fifo_valid;
   assign pop      = wb_valid && wb_ready;
   assign wb_data  = wb_valid ? fifo_head.data : '0;
   assign wb_rd    = wb_valid ? fifo_head.rd   : '0;
   assign wb_src   = wb_valid ? fifo_head.src  : 1'b0;

   // The passthrough is only cross-checked, never trusted; stale returns with no local tag are ignored.
   assert property (@(posedge clk) disable iff (!rstn)
      tags[LATENCY-1].valid |-> (sq_flagout && (sq_addout == tags[LATENCY-1].rd)));

endmodule
`default_nettype wire

// File: tb/tb_fsqrt_sched.sv
`default_nettype none
// tb_fsqrt_sched : directed stimulus, queue scoreboard with independent monitor,
//                  behavioural fixed-latency fsqrt unit.
module tb_fsqrt_sched;

   localparam int LAT = 2;
   localparam int DEP = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_x, req1_x;
   logic [4:0]  req0_rd, req1_rd;
   logic [31:0] sq_x, sq_y;
   logic        sq_flagin, sq_flagout;
   logic [4:0]  sq_addin, sq_addout;
   logic        wb_valid, wb_ready, wb_src;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   always #5 clk = ~clk;

   fsqrt_sched #(.LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_rd    (req0_rd),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_rd    (req1_rd),
      .sq_x       (sq_x),
      .sq_flagin  (sq_flagin),
      .sq_addin   (sq_addin),
      .sq_y       (sq_y),
      .sq_flagout (sq_flagout),
      .sq_addout  (sq_addout),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_data    (wb_data),
      .wb_rd      (wb_rd),
      .wb_src     (wb_src)
   );

   // Hand-computed square roots of the operands used below.
   function automatic logic [31:0] sqrt_tab(input logic [31:0] x);
      case (x)
         32'h3F800000: return 32'h3F800000;  // 1  -> 1
         32'h40800000: return 32'h40000000;  // 4  -> 2
         32'h41100000: return 32'h40400000;  // 9  -> 3
         32'h41800000: return 32'h40800000;  // 16 -> 4
         32'h41C80000: return 32'h40A00000;  // 25 -> 5
         32'h42100000: return 32'h40C00000;  // 36 -> 6
         default:      return 32'h7FC00000;
      endcase
   endfunction

   // External fsqrt unit: plain delay line, deliberately not reset.
   logic [31:0] p_y [LAT];
   logic        p_f [LAT];
   logic [4:0]  p_a [LAT];
   always @(posedge clk) begin
      p_y[0] <= sqrt_tab(sq_x);
      p_f[0] <= sq_flagin;
      p_a[0] <= sq_addin;
      for (int i = 1; i < LAT; i++) begin
         p_y[i] <= p_y[i-1];
         p_f[i] <= p_f[i-1];
         p_a[i] <= p_a[i-1];
      end
   end
   assign sq_y       = p_y[LAT-1];
   assign sq_flagout = p_f[LAT-1];
   assign sq_addout  = p_a[LAT-1];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        src;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;
   int   grant_q[$];
   int   acc_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   // Monitor: records accepts into the scoreboard, compares writebacks.
   logic        pv = 1'b0;
   logic        pr = 1'b0;
   logic [37:0] pw = '0;
   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
      end else begin
         if (req0_valid && req0_ready && req1_valid && req1_ready)
            check("single_grant", 1, 0);
         if (req0_valid && req0_ready) begin
            check("issue0", {sq_flagin, sq_addin, sq_x}, {1'b1, req0_rd, req0_x});
            exp_q.push_back('{sqrt_tab(req0_x), req0_rd, 1'b0});
            grant_q.push_back(0);
            acc_cnt++;
         end else if (req1_valid && req1_ready) begin
            check("issue1", {sq_flagin, sq_addin, sq_x}, {1'b1, req1_rd, req1_x});
            exp_q.push_back('{sqrt_tab(req1_x), req1_rd, 1'b1});
            grant_q.push_back(1);
            acc_cnt++;
         end else begin
            check("idle_issue", {sq_flagin, sq_addin, sq_x}, 64'h0);
         end
         if (pv && !pr && wb_valid)
            check("stall_stable", {wb_data, wb_rd, wb_src}, pw);
         if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wb: got data %h rd %0d src %0d, expected no result",
                        wb_data, wb_rd, wb_src);
            end else begin
               e = exp_q.pop_front();
               check("wb_result", {wb_data, wb_rd, wb_src}, {e.data, e.rd, e.src});
            end
         end
      end
      pv = rstn && wb_valid;
      pr = wb_ready;
      pw = {wb_data, wb_rd, wb_src};
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] xs [4];
   initial begin
      xs[0] = 32'h42100000; xs[1] = 32'h40800000; xs[2] = 32'h41800000; xs[3] = 32'h3F800000;
      rstn = 1'b0; wb_ready = 1'b1;
      req0_valid = 1'b1; req0_x = 32'h40800000; req0_rd = 5'd3;
      req1_valid = 1'b1; req1_x = 32'h41100000; req1_rd = 5'd2;
      repeat (2) tick();
      @(negedge clk);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      check("rst_issue", {sq_flagin, sq_addin, sq_x}, 0);
      check("rst_wb", {wb_valid, wb_data, wb_rd, wb_src}, 0);

      // Single operand, first cycle out of reset: wb_valid at t+3.
      tick();
      rstn = 1'b1; req1_valid = 1'b0;
      @(negedge clk); check("first_accept", req0_ready, 1);
      tick(); req0_valid = 1'b0;
      @(negedge clk); check("lat_t1", wb_valid, 0);
      tick();
      @(negedge clk); check("lat_t2", wb_valid, 0);
      tick();
      @(negedge clk); check("lat_t3", wb_valid, 1);
      drain(20);

      // Reset with both valid: req0 first, then strict alternation.
      rstn = 1'b0;
      req0_valid = 1'b1; req0_x = 32'h3F800000; req0_rd = 5'd1;
      req1_valid = 1'b1; req1_x = 32'h41100000; req1_rd = 5'd2;
      tick();
      rstn = 1'b1;
      grant_q.delete();
      repeat (8) tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr_count", grant_q.size(), 8);
      for (int i = 0; i < grant_q.size(); i++)
         check("rr_order", grant_q[i], i % 2);
      drain(20);

      // Credit limit with writeback stalled.
      wb_ready = 1'b0; acc_cnt = 0;
      req0_valid = 1'b1; req0_x = 32'h41C80000; req0_rd = 5'd5;
      repeat (10) tick();
      check("credit_accepts", acc_cnt, 4);
      @(negedge clk); check("credit_block", req0_ready, 0);
      tick(); wb_ready = 1'b1;
      @(negedge clk); check("pop_no_credit", req0_ready, 0);
      tick(); wb_ready = 1'b0;
      @(negedge clk); check("credit_regain", req0_ready, 1);
      tick();
      @(negedge clk); check("credit_reblock", req0_ready, 0);
      check("credit_total", acc_cnt, 5);
      req0_valid = 1'b0; wb_ready = 1'b1;
      drain(40);

      // Burst of four from req1 alone, drained with toggling wb_ready.
      wb_ready = 1'b0; acc_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         req1_valid = 1'b1; req1_x = xs[i]; req1_rd = 5'(10 + i);
         tick();
      end
      req1_valid = 1'b0;
      check("burst_accepts", acc_cnt, 4);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         wb_ready = (i % 2) == 0;
         tick();
      end
      wb_ready = 1'b1;
      drain(20);

      // Reset with two in flight and two buffered.
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1; req0_x = xs[i]; req0_rd = 5'(20 + i);
         tick();
      end
      req0_valid = 1'b0; rstn = 1'b0;
      @(negedge clk); check("midrst_wb", wb_valid, 0);
      tick(); rstn = 1'b1; wb_ready = 1'b1;
      @(negedge clk); check("postrst_wb", wb_valid, 0);
      check("postrst_flush", exp_q.size(), 0);
      repeat (6) tick();
      req0_valid = 1'b1; req0_x = 32'h41800000; req0_rd = 5'd7;
      tick();
      req0_valid = 1'b0;
      drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
